// File: rtl/mult_fu.sv
// Multiply functional unit: pipelined 64x64 (low half) multiplier with a tag
// shadow pipe, credit-based admission and an in-order result FIFO to the CDB.
module mult_fu #(
  parameter int unsigned NUM_STAGE  = 8,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [63:0]      issue_opa,
  input  logic [63:0]      issue_opb,
  input  logic [7:0]       issue_imm,
  input  logic             issue_use_imm,
  input  logic             flush,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [63:0]      cdb_value,
  input  logic             cdb_grant
);

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned CHUNK_W = DATA_W / NUM_STAGE;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } result_t;

  // Multiplier pipe: each stage folds in one CHUNK_W-bit digit of the multiplier.
  logic [DATA_W-1:0] st_mcand  [NUM_STAGE-1];
  logic [DATA_W-1:0] st_mplier [NUM_STAGE-1];
  logic [DATA_W-1:0] st_prod   [NUM_STAGE];
  logic [NUM_STAGE-1:0] st_done;

  // Shadow pipe carrying the op's ROB tag; valids are squashable, done is not.
  logic [NUM_STAGE-1:0] sh_valid;
  logic [TAG_W-1:0]     sh_tag [NUM_STAGE];

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  result_t          fifo_mem [FIFO_DEPTH];

  logic              accept;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] mplier_in;
  result_t           head;

  // Partial product of one multiplier digit, already shifted to its weight.
  function automatic logic [DATA_W-1:0] partial(input logic [DATA_W-1:0] mcand,
                                                input logic [DATA_W-1:0] mplier,
                                                input int unsigned       idx);
    logic [CHUNK_W-1:0] digit;
    digit = mplier[idx*CHUNK_W +: CHUNK_W];
    return (mcand * DATA_W'(digit)) << (idx * CHUNK_W);
  endfunction

  // Circular pointer advance with wrap at FIFO_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Admission, handshake and FIFO traffic decode.
  always_comb begin
    mplier_in   = issue_use_imm ? DATA_W'(issue_imm) : issue_opb;
    issue_ready = !reset && !flush &&
                  ((SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
    accept      = issue_valid && issue_ready;
    push        = st_done[NUM_STAGE-1] && sh_valid[NUM_STAGE-1] && !flush && !reset;
    cdb_valid   = (fifo_count != '0);
    pop         = cdb_valid && cdb_grant && !flush;
    head        = fifo_mem[rd_ptr];
    cdb_tag     = cdb_valid ? head.tag : '0;
    cdb_value   = cdb_valid ? head.value : '0;
  end

  // Multiplier and tag datapath; free-running, qualified by done/valid bits.
  always_ff @(posedge clock) begin
    st_mcand[0]  <= issue_opa;
    st_mplier[0] <= mplier_in;
    st_prod[0]   <= partial(issue_opa, mplier_in, 0);
    sh_tag[0]    <= issue_tag;
    for (int unsigned s = 1; s < NUM_STAGE; s++) begin
      st_prod[s] <= st_prod[s-1] + partial(st_mcand[s-1], st_mplier[s-1], s);
      sh_tag[s]  <= sh_tag[s-1];
    end
    for (int unsigned s = 1; s < NUM_STAGE - 1; s++) begin
      st_mcand[s]  <= st_mcand[s-1];
      st_mplier[s] <= st_mplier[s-1];
    end
  end

  // Multiplier done chain; only reset clears it, flushed ops drain out unclaimed.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_done <= '0;
    end else begin
      st_done <= {st_done[NUM_STAGE-2:0], accept};
    end
  end

  // Shadow valids, credit counters and FIFO pointers; flush acts like reset.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      sh_valid   <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      sh_valid   <= {sh_valid[NUM_STAGE-2:0], accept};
      inflight   <= inflight + CNT_W'(accept) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Result storage write.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{tag: sh_tag[NUM_STAGE-1], value: st_prod[NUM_STAGE-1]};
    end
  end

endmodule
